// File: rtl/a5_keystream_engine_if.sv
// rtl/a5_keystream_engine_if.sv - keystream chunk handshake between the A5/1 engine and its consumer
interface a5_keystream_engine_if #(
  parameter int STEPS = 4
);
  logic             ks_valid;
  logic             ks_ready;
  logic [STEPS-1:0] ks_data;
  logic             ks_last;

  modport master (output ks_valid, output ks_data, output ks_last, input  ks_ready);
  modport slave  (input  ks_valid, input  ks_data, input  ks_last, output ks_ready);
endinterface

// File: rtl/a5_keystream_engine.sv
// rtl/a5_keystream_engine.sv - A5/1 keystream generator, STEPS majority-clocked steps per clock
module a5_keystream_engine #(
  parameter int STEPS     = 4,
  parameter int KEY_W     = 64,
  parameter int FRAME_W   = 22,
  parameter int MIX_STEPS = 100,
  parameter int KS_LEN    = 228
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [KEY_W-1:0]   key,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               done,
  a5_keystream_engine_if.master ks
);
  localparam int MIX_CYC   = MIX_STEPS / STEPS;
  localparam int KS_CHUNKS = KS_LEN / STEPS;
  localparam int MAX_A     = (KEY_W > FRAME_W) ? KEY_W : FRAME_W;
  localparam int MAX_B     = (MIX_CYC > KS_CHUNKS) ? MIX_CYC : KS_CHUNKS;
  localparam int CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_KEY, S_LOAD_FRAME, S_MIX, S_STREAM} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic [FRAME_W-1:0] frame_q;
  logic [19:1]        r1_q, r1_ld, r1_mx;
  logic [22:1]        r2_q, r2_ld, r2_mx;
  logic [23:1]        r3_q, r3_ld, r3_mx;
  logic [STEPS-1:0]   ks_data_q, chunk;
  logic               ks_valid_q, ks_last_q, done_q;
  logic               load_bit, maj;
  logic               start_go, load_en, mix_en, gen_en, cnt_clr, cnt_inc, finish, accept;

  // Key/frame loading clocks all three registers regardless of majority
  assign load_bit = (state_q == S_LOAD_KEY) ? key_q[0] : frame_q[0];
  assign r1_ld = {r1_q[18:1], r1_q[19] ^ r1_q[18] ^ r1_q[17] ^ r1_q[14] ^ load_bit};
  assign r2_ld = {r2_q[21:1], r2_q[22] ^ r2_q[21] ^ load_bit};
  assign r3_ld = {r3_q[22:1], r3_q[23] ^ r3_q[22] ^ r3_q[21] ^ r3_q[8] ^ load_bit};

  always_comb begin
    r1_mx = r1_q;
    r2_mx = r2_q;
    r3_mx = r3_q;
    chunk = '0;
    maj   = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      maj = (r1_mx[9] & r2_mx[11]) | (r1_mx[9] & r3_mx[11]) | (r2_mx[11] & r3_mx[11]);
      if (r1_mx[9] == maj)  r1_mx = {r1_mx[18:1], r1_mx[19] ^ r1_mx[18] ^ r1_mx[17] ^ r1_mx[14]};
      if (r2_mx[11] == maj) r2_mx = {r2_mx[21:1], r2_mx[22] ^ r2_mx[21]};
      if (r3_mx[11] == maj) r3_mx = {r3_mx[22:1], r3_mx[23] ^ r3_mx[22] ^ r3_mx[21] ^ r3_mx[8]};
      chunk[i] = r1_mx[19] ^ r2_mx[22] ^ r3_mx[23];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    load_en  = 1'b0;
    mix_en   = 1'b0;
    gen_en   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    finish   = 1'b0;
    accept   = ks_valid_q & ks.ks_ready;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_go = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = S_LOAD_KEY;
        end
      end
      S_LOAD_KEY: begin
        load_en = 1'b1;
        if (cnt_q == CNT_W'(KEY_W - 1)) begin
          cnt_clr = 1'b1;
          state_d = S_LOAD_FRAME;
        end else cnt_inc = 1'b1;
      end
      S_LOAD_FRAME: begin
        load_en = 1'b1;
        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
          cnt_clr = 1'b1;
          state_d = S_MIX;
        end else cnt_inc = 1'b1;
      end
      S_MIX: begin
        mix_en = 1'b1;
        if (cnt_q == CNT_W'(MIX_CYC - 1)) begin
          cnt_clr = 1'b1;
          state_d = S_STREAM;
        end else cnt_inc = 1'b1;
      end
      S_STREAM: begin
        if (accept && ks_last_q) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else if ((!ks_valid_q || ks.ks_ready) && (cnt_q != CNT_W'(KS_CHUNKS))) begin
          gen_en  = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      start_go = 1'b0;
      load_en  = 1'b0;
      mix_en   = 1'b0;
      gen_en   = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      finish   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      key_q      <= '0;
      frame_q    <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
      ks_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (abort) begin
        ks_valid_q <= 1'b0;
        ks_last_q  <= 1'b0;
        cnt_q      <= '0;
      end else begin
        if (cnt_clr)      cnt_q <= '0;
        else if (cnt_inc) cnt_q <= cnt_q + 1'b1;

        if (start_go) begin
          key_q   <= key;
          frame_q <= frame;
          r1_q    <= '0;
          r2_q    <= '0;
          r3_q    <= '0;
        end else if (load_en) begin
          r1_q <= r1_ld;
          r2_q <= r2_ld;
          r3_q <= r3_ld;
          if (state_q == S_LOAD_KEY) key_q   <= key_q >> 1;
          else                       frame_q <= frame_q >> 1;
        end else if (mix_en || gen_en) begin
          r1_q <= r1_mx;
          r2_q <= r2_mx;
          r3_q <= r3_mx;
        end

        // A new chunk may replace one being accepted on the same edge
        if (gen_en) begin
          ks_data_q  <= chunk;
          ks_valid_q <= 1'b1;
          ks_last_q  <= (cnt_q == CNT_W'(KS_CHUNKS - 1));
        end else if (accept) begin
          ks_valid_q <= 1'b0;
          ks_last_q  <= 1'b0;
        end
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign ks.ks_valid = ks_valid_q;
  assign ks.ks_data  = ks_data_q;
  assign ks.ks_last  = ks_last_q;
endmodule

// File: tb/tb_a5_keystream_engine.sv
// tb/tb_a5_keystream_engine.sv - directed-vector bench for a5_keystream_engine at STEPS 4, 2 and 1
module tb_a5_keystream_engine;
  localparam logic [63:0]  KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0]  FRAME = 22'h134;
  localparam logic [119:0] EXP_A = 120'h534EAA582FE8151AB6E1855A728C00;
  localparam logic [119:0] EXP_B = 120'h24FD35A35D5FB6526D32F906DF1AC0;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [63:0] key_in;
  logic [21:0] frame_in;
  logic        throttle, clr;
  logic        busy4, busy2, busy1, done4, done2, done1;
  int          n_vec = 0;
  int          n_mis = 0;

  a5_keystream_engine_if #(.STEPS(4)) ks4 ();
  a5_keystream_engine_if #(.STEPS(2)) ks2 ();
  a5_keystream_engine_if #(.STEPS(1)) ks1 ();

  a5_keystream_engine #(.STEPS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key(key_in), .frame(frame_in), .busy(busy4), .done(done4), .ks(ks4));
  a5_keystream_engine #(.STEPS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key(key_in), .frame(frame_in), .busy(busy2), .done(done2), .ks(ks2));
  a5_keystream_engine #(.STEPS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key(key_in), .frame(frame_in), .busy(busy1), .done(done1), .ks(ks1));

  always #5 clk = ~clk;

  assign ks2.ks_ready = 1'b1;
  assign ks1.ks_ready = 1'b1;

  logic       ksv[3], ksl[3], ksr[3], dn[3], bsy[3];
  logic [3:0] ksd[3];
  assign ksv[0] = ks4.ks_valid; assign ksv[1] = ks2.ks_valid; assign ksv[2] = ks1.ks_valid;
  assign ksl[0] = ks4.ks_last;  assign ksl[1] = ks2.ks_last;  assign ksl[2] = ks1.ks_last;
  assign ksr[0] = ks4.ks_ready; assign ksr[1] = ks2.ks_ready; assign ksr[2] = ks1.ks_ready;
  assign ksd[0] = ks4.ks_data;  assign ksd[1] = {2'b00, ks2.ks_data}; assign ksd[2] = {3'b000, ks1.ks_data};
  assign dn[0]  = done4; assign dn[1]  = done2; assign dn[2]  = done1;
  assign bsy[0] = busy4; assign bsy[1] = busy2; assign bsy[2] = busy1;

  logic [227:0] got[3];
  int           nbits[3], nch[3], nlast[3], lastpos[3], ndone[3], errs[3], stab[3];
  logic         hold[3];
  logic [3:0]   prevd[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic exp_bit(input int i);
    logic [119:0] a, b;
    a = EXP_A;
    b = EXP_B;
    return (i < 114) ? a[119 - i] : b[119 - (i - 114)];
  endfunction

  function automatic logic [3:0] exp_nib(input int n);
    logic [3:0] v;
    for (int b = 0; b < 4; b++) v[b] = exp_bit(4 * n + b);
    return v;
  endfunction

  // Consumer-side monitor: records accepted bits and protocol events per instance
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (clr) begin
          got[g] = '0; nbits[g] = 0; nch[g] = 0; nlast[g] = 0; lastpos[g] = 0;
          ndone[g] = 0; errs[g] = 0; stab[g] = 0; hold[g] = 1'b0; prevd[g] = '0;
        end else begin
          if (hold[g] && ksd[g] != prevd[g]) stab[g]++;
          if (ksv[g] && ksr[g]) begin
            for (int b = 0; b < (4 >> g); b++) begin
              if (nbits[g] < 228) got[g][nbits[g]] = ksd[g][b];
              nbits[g]++;
            end
            nch[g]++;
            if (ksl[g]) begin
              nlast[g]++;
              lastpos[g] = nch[g];
            end
          end
          if (ksl[g] && !ksv[g]) errs[g]++;
          if (dn[g]) begin
            ndone[g]++;
            if (bsy[g]) errs[g]++;
          end
          hold[g]  = ksv[g] && !ksr[g];
          prevd[g] = ksd[g];
        end
      end
    end
  end

  initial begin
    ks4.ks_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ks4.ks_ready = throttle ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  task automatic clear_col();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic launch();
    key_in   = KEY;
    frame_in = FRAME;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_nbits_g%0d", tag, g), nbits[g], 228);
      chk($sformatf("%s_nchunks_g%0d", tag, g), nch[g], 228 / (4 >> g));
      chk($sformatf("%s_nlast_g%0d", tag, g), nlast[g], 1);
      chk($sformatf("%s_lastpos_g%0d", tag, g), lastpos[g], 228 / (4 >> g));
      chk($sformatf("%s_ndone_g%0d", tag, g), ndone[g], 1);
      chk($sformatf("%s_proto_g%0d", tag, g), errs[g], 0);
      chk($sformatf("%s_stable_g%0d", tag, g), stab[g], 0);
      for (int n = 0; n < 57; n++)
        chk($sformatf("%s_ks_g%0d_n%0d", tag, g, n), got[g][4 * n +: 4], exp_nib(n));
    end
  endtask

  task automatic run_vec(input string tag, input bit thr);
    int  lat;
    bit  found, all_done;
    clear_col();
    throttle = thr;
    launch();
    lat   = 0;
    found = 1'b0;
    for (int n = 1; n <= 400 && !found; n++) begin
      if (n == 50) begin start = 1'b1; key_in = '0; frame_in = '1; end
      if (n == 51) begin start = 1'b0; key_in = KEY; frame_in = FRAME; end
      @(posedge clk);
      #1;
      if (ksv[0]) begin found = 1'b1; lat = n; end
    end
    chk({tag, "_latency"}, lat, 112);
    all_done = 1'b0;
    for (int n = 0; n < 3000 && !all_done; n++) begin
      @(posedge clk);
      #1;
      all_done = (ndone[0] > 0) && (ndone[1] > 0) && (ndone[2] > 0);
    end
    chk({tag, "_done_seen"}, all_done, 1'b1);
    repeat (3) @(posedge clk);
    #1 throttle = 1'b0;
    check_run(tag);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; throttle = 1'b0; clr = 1'b0;
    key_in = '0; frame_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy4, 1'b0);
    chk("rst_valid", ks4.ks_valid, 1'b0);
    chk("rst_last", ks4.ks_last, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_data", ks4.ks_data, 4'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec("plain", 1'b0);
    run_vec("throttled", 1'b1);

    clear_col();
    launch();
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(posedge clk);
      #2;
      if (nch[0] >= 9 && ksv[0]) found = 1'b1;
    end
    chk("abort_reached", found, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy4, 1'b0);
    chk("abort_valid", ks4.ks_valid, 1'b0);
    chk("abort_last", ks4.ks_last, 1'b0);
    chk("abort_busy_s1", busy1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", ndone[0], 0);
    run_vec("after_abort", 1'b0);

    clear_col();
    launch();
    repeat (95) @(posedge clk);
    #1;
    chk("mix_busy_pre", busy4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy4, 1'b0);
    chk("arst_valid", ks4.ks_valid, 1'b0);
    chk("arst_last", ks4.ks_last, 1'b0);
    chk("arst_done", done4, 1'b0);
    chk("arst_data", ks4.ks_data, 4'h0);
    chk("arst_busy_s1", busy1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_vec("after_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
